// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared state type and divide/phase helpers for clkgen_multi_div
// Consumed by clkgen_channel (CLKGEN_PHASE_EN selects phase support) and the top.
package clkgen_pkg;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } clk_state_e;

  function automatic int unsigned chan_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  // d must already be clamped, so d-1 never underflows
  function automatic int unsigned clamp_phase(input int unsigned d, input int unsigned p);
    return (p >= d) ? d - 1 : p;
  endfunction

  function automatic int unsigned start_value(input int unsigned d, input int unsigned p);
    return (p == 0) ? 0 : d - p;
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// rtl/clkgen_channel.sv - one divided-clock channel: div/phase regs, counter, gated outputs
// Phase registers exist only when CLKGEN_PHASE_EN is defined; otherwise every restart starts at 0.
module clkgen_channel
  import clkgen_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter int DEFAULT_DIV   = 2,
  parameter int DEFAULT_PHASE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [DIV_W-1:0] i_cfg_phase,
  input  logic             i_locked_nxt,
  output logic             o_outclk,
  output logic             o_outclk_en
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(DEFAULT_DIV));

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_outclk;
  logic             r_outclk_en;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_start;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W:0]   w_half;

  assign w_div_nxt = i_load ? DIV_W'(clamp_div(32'(i_cfg_div))) : r_div;

`ifdef CLKGEN_PHASE_EN
  localparam logic [DIV_W-1:0] RST_PHASE = DIV_W'(clamp_phase(32'(RST_DIV), DEFAULT_PHASE));
  localparam logic [DIV_W-1:0] RST_START = DIV_W'(start_value(32'(RST_DIV), 32'(RST_PHASE)));

  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] w_phase_nxt;

  assign w_phase_nxt = i_load ? DIV_W'(clamp_phase(32'(w_div_nxt), 32'(i_cfg_phase))) : r_phase;
  assign w_start     = DIV_W'(start_value(32'(w_div_nxt), 32'(w_phase_nxt)));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_phase <= RST_PHASE;
    else       r_phase <= w_phase_nxt;
  end
`else
  localparam logic [DIV_W-1:0] RST_START = '0;

  logic w_unused_phase;
  assign w_unused_phase = ^{i_cfg_phase, DIV_W'(DEFAULT_PHASE)};
  assign w_start        = '0;
`endif

  // Outputs are computed from next-state values so the registers line up with r_cnt
  assign w_cnt_nxt = i_restart                    ? w_start :
                     (r_cnt == r_div - DIV_W'(1)) ? '0      :
                                                    r_cnt + DIV_W'(1);
  assign w_half    = ({1'b0, w_div_nxt} + (DIV_W+1)'(1)) >> 1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div       <= RST_DIV;
      r_cnt       <= RST_START;
      r_outclk    <= 1'b0;
      r_outclk_en <= 1'b0;
    end else begin
      r_div       <= w_div_nxt;
      r_cnt       <= w_cnt_nxt;
      r_outclk    <= i_locked_nxt & ({1'b0, w_cnt_nxt} < w_half);
      r_outclk_en <= i_locked_nxt & (w_cnt_nxt == '0);
    end
  end

  assign o_outclk    = r_outclk;
  assign o_outclk_en = r_outclk_en;

endmodule

// File: rtl/clkgen_multi_div.sv
// rtl/clkgen_multi_div.sv - multi-channel clock divider with lock FSM and runtime config port
// Channel phase support is compiled in with CLKGEN_PHASE_EN.
module clkgen_multi_div
  import clkgen_pkg::*;
#(
  parameter int  NUM_CLOCKS    = 2,
  parameter int  DIV_W         = 8,
  parameter int  LOCK_CYCLES   = 16,
  parameter int  DEFAULT_DIV   = 2,
  parameter int  DEFAULT_PHASE = 0,
  localparam int CHAN_W        = chan_width(NUM_CLOCKS)
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int              LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  clk_state_e        r_state;
  clk_state_e        w_state_nxt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [LOCK_W-1:0] w_lock_cnt_nxt;
  logic              r_locked;
  logic              r_cfg_ready;
  logic              w_locked_nxt;
  logic              w_cfg_fire;
  logic              w_cfg_hit;

  assign w_cfg_fire = cfg_valid & r_cfg_ready;
  // Out-of-range channels still handshake but must not disturb running outputs
  assign w_cfg_hit  = w_cfg_fire & (32'(cfg_chan) < 32'(NUM_CLOCKS));

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= ST_SETTLE;
      r_lock_cnt  <= '0;
      r_locked    <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_locked    <= w_locked_nxt;
      r_cfg_ready <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ST_SETTLE: begin
        if (r_lock_cnt == LOCK_LAST) w_state_nxt    = ST_LOCKED;
        else                         w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
      end
      ST_LOCKED: ;
      default:   w_state_nxt = ST_SETTLE;
    endcase
    if (w_cfg_hit) begin
      w_state_nxt    = ST_SETTLE;
      w_lock_cnt_nxt = '0;
    end
    w_locked_nxt = (w_state_nxt == ST_LOCKED);
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    logic w_load;
    assign w_load = w_cfg_hit & (cfg_chan == CHAN_W'(g));

    clkgen_channel #(
      .DIV_W         (DIV_W),
      .DEFAULT_DIV   (DEFAULT_DIV),
      .DEFAULT_PHASE (DEFAULT_PHASE)
    ) u_chan (
      .i_clk        (refclk),
      .i_rst        (rst),
      .i_load       (w_load),
      .i_restart    (w_cfg_hit),
      .i_cfg_div    (cfg_div),
      .i_cfg_phase  (cfg_phase),
      .i_locked_nxt (w_locked_nxt),
      .o_outclk     (outclk[g]),
      .o_outclk_en  (outclk_en[g])
    );
  end

  assign locked    = r_locked;
  assign cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_clkgen_multi_div.sv
// tb/tb_clkgen_multi_div.sv - randomized bench for clkgen_multi_div against a closed-form model
// Model honours phase only when CLKGEN_PHASE_EN is defined, matching the DUT build.
module tb_clkgen_multi_div;

  localparam int NCLK = 3;
  localparam int DW   = 8;
  localparam int LOCK = 16;
  localparam int DDIV = 2;
  localparam int DPH  = 0;
  localparam int CW   = 2;

  logic            refclk    = 1'b0;
  logic            rst       = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CW-1:0]   cfg_chan  = '0;
  logic [DW-1:0]   cfg_div   = '0;
  logic [DW-1:0]   cfg_phase = '0;
  logic [NCLK-1:0] outclk;
  logic [NCLK-1:0] outclk_en;
  logic            locked;

  always #5 refclk = ~refclk;

  clkgen_multi_div #(
    .NUM_CLOCKS    (NCLK),
    .DIV_W         (DW),
    .LOCK_CYCLES   (LOCK),
    .DEFAULT_DIV   (DDIV),
    .DEFAULT_PHASE (DPH)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit m_valid  = 0;
  int m_rst_cyc;
  int m_restart;
  int m_div [NCLK];
  int m_ph  [NCLK];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int m_clamp_div(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int m_clamp_ph(input int d, input int p);
    return (p >= d) ? d - 1 : p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCLK; i++) begin
      m_div[i] = m_clamp_div(DDIV);
      m_ph[i]  = m_clamp_ph(m_div[i], DPH);
    end
  endtask

  // Channel position = cycles since restart minus phase, modulo div
  task automatic compare_outputs();
    int age;
    int ph;
    int cnt;
    bit lk;
    logic [NCLK-1:0] en_e;
    logic [NCLK-1:0] clk_e;
    age = cyc - m_restart;
    lk  = (age >= LOCK);
    for (int i = 0; i < NCLK; i++) begin
`ifdef CLKGEN_PHASE_EN
      ph = m_ph[i];
`else
      ph = 0;
`endif
      cnt      = (((age - ph) % m_div[i]) + m_div[i]) % m_div[i];
      en_e[i]  = lk && (cnt == 0);
      clk_e[i] = lk && (cnt < (m_div[i] + 1) / 2);
    end
    check("cfg_ready", 32'(cfg_ready), 32'(cyc > m_rst_cyc));
    check("locked",    32'(locked),    32'(lk));
    check("outclk_en", 32'(outclk_en), 32'(en_e));
    check("outclk",    32'(outclk),    32'(clk_e));
  endtask

  task automatic step();
    if (m_valid) compare_outputs();
    @(posedge refclk);
    if (rst) begin
      model_reset();
      m_valid   = 1;
      m_rst_cyc = cyc + 1;
      m_restart = cyc + 1;
    end else if (m_valid && cfg_valid && (cyc > m_rst_cyc) && (int'(cfg_chan) < NCLK)) begin
      m_div[cfg_chan] = m_clamp_div(int'(cfg_div));
      m_ph[cfg_chan]  = m_clamp_ph(m_div[cfg_chan], int'(cfg_phase));
      m_restart       = cyc + 1;
    end
    cyc++;
    @(negedge refclk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send_cfg(input int ch, input int d, input int p);
    cfg_valid = 1'b1;
    cfg_chan  = CW'(ch);
    cfg_div   = DW'(d);
    cfg_phase = DW'(p);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    @(negedge refclk);
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_chan  = CW'(0);
    cfg_div   = DW'(7);
    run(3);
    rst = 1'b0;
    step();
    cfg_valid = 1'b0;
    run(30);

    send_cfg(1, 5, 2);
    run(40);
    send_cfg(0, 0, 0);
    run(30);
    send_cfg(2, 4, 7);
    run(30);
    send_cfg(3, 7, 1);
    run(20);

    send_cfg(0, 3, 1);
    run(10);
    send_cfg(1, 6, 4);
    run(4);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(30);

    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (r < 7) begin
        send_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 11)));
      end
      run(int'($urandom_range(0, 25)));
    end
    run(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clkgen_multi_div.md
Name: clkgen_multi_div

Overview:
- Parametrised successor to the fixed two-output system clock block.
- Generates NUM_CLOCKS clock-enable strobes and registered divided clock waveforms from one reference clock.
- Each channel's divide ratio and phase offset can be changed at runtime through a valid/ready config port. A locked flag mimics PLL lock semantics.
- Sits beside the system PLL and feeds slow peripherals (SDRAM refresh ticks, UART/I2C baud, audio frame strobes) in the Nios system.

Parameters:
- NUM_CLOCKS, 2, number of output channels (1..16)
- DIV_W, 8, width of divide and phase values
- LOCK_CYCLES, 16, refclk cycles spent settling before locked asserts (>=1)
- DEFAULT_DIV, 2, divide ratio loaded into every channel at reset
- DEFAULT_PHASE, 0, phase offset loaded into every channel at reset

Ports:
- refclk  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept
- cfg_chan  in  max(1,$clog2(NUM_CLOCKS))  target channel
- cfg_div  in  DIV_W  new divide ratio
- cfg_phase  in  DIV_W  new phase offset, in refclk cycles
- outclk  out  NUM_CLOCKS  divided clock waveform per channel, registered
- outclk_en  out  NUM_CLOCKS  one-cycle strobe per channel, high on each outclk rising edge
- locked  out  1  outputs stable

Behaviour:
- Interface: one clock (refclk); reset rst is synchronous and active-high.
- Reset values:
  - outclk, outclk_en, locked, cfg_ready all 0.
  - Every channel loaded with DEFAULT_DIV and DEFAULT_PHASE.
  - FSM enters SETTLE with lock_cnt=0.
  - All channel counters load their start value.
- Clamping, applied on load:
  - div 0 becomes 1.
  - phase >= div becomes div-1.
- Per-channel counter: cnt counts 0..div-1 and wraps to 0. Start value is 0 if phase==0, else div-phase. Result: the first cnt==0 occurs exactly phase cycles after a restart.
- Waveforms, registered and aligned with cnt:
  - outclk_en[i]=1 iff cnt_i==0.
  - outclk[i]=1 iff cnt_i < ceil(div/2). Odd div gives high one cycle longer than low.
  - div=1 gives outclk and outclk_en constantly 1.
- FSM states SETTLE and LOCKED:
  - SETTLE: lock_cnt increments each cycle. When lock_cnt==LOCK_CYCLES-1, go to LOCKED; locked=1 on the next cycle.
  - Counters run during SETTLE, but outclk and outclk_en are forced to 0 unless locked=1.
  - Timing: with rst low from cycle 0, locked=1 in cycle LOCK_CYCLES.
- cfg_ready is 1 in every cycle after the first post-reset cycle, in both states.
- Config transfer: occurs when cfg_valid && cfg_ready in cycle T. In T+1:
  - The target channel's div/phase registers take the clamped values.
  - ALL channel counters restart from their start values, which keeps channels phase-aligned.
  - FSM goes to SETTLE, lock_cnt=0, locked=0, and outputs are forced to 0.
- A transfer during SETTLE restarts settling.
- cfg_chan >= NUM_CLOCKS: the transfer completes but is ignored. No restart, and locked is unchanged.
- rst mid-operation, including mid-SETTLE: full return to reset values and defaults.

Optional Feature:
- Macro: CLKGEN_PHASE_EN.
- Defined: per-channel phase registers exist and cfg_phase is honoured as above.
- Undefined:
  - Phase registers are removed, and cfg_phase and DEFAULT_PHASE are ignored.
  - Start value is always 0, so every channel strobes in the first cycle after a restart.
  - All other behaviour is identical.

Decomposition:
- Package clkgen_pkg holds:
  - FSM state enum (SETTLE, LOCKED)
  - clamp function for div/phase
  - start-value function
  - CHAN_W localparam derivation
- Sub-module clkgen_channel holds one channel: div/phase registers, counter, start-value load, outclk/outclk_en generation, gated by a top-level locked input.
- Top level holds the FSM, lock counter, config decode and NUM_CLOCKS instances.

Test Plan:
- Default params, rst released at cycle 0:
  - locked=0 through cycle 15 and 1 at cycle 16.
  - From cycle 16, outclk_en[1:0] alternates 11,00,11,00 and outclk matches.
  - cfg_ready=1 from cycle 1.
- In LOCKED, send cfg_chan=1, cfg_div=5, cfg_phase=2:
  - locked drops next cycle and returns 16 cycles later.
  - Thereafter outclk_en[1] pulses every 5 cycles, 2 cycles after channel-0 strobes at restart alignment.
  - outclk[1] pattern is 3 high, 2 low.
- cfg_div=0 on channel 0: after relock, outclk_en[0] and outclk[0] are constantly 1.
- cfg_div=4, cfg_phase=7: phase clamped to 3, so first strobe occurs 3 cycles after restart. With CLKGEN_PHASE_EN undefined, the first strobe is in the restart cycle.
- cfg_chan=3 with NUM_CLOCKS=2 while locked: cfg_ready handshake completes, locked stays 1, and no output pattern changes.
- Config accepted at lock_cnt=10, then rst asserted 5 cycles later:
  - The config restarts settling (lock_cnt back to 0).
  - After the reset, all channels are back at div 2, and locked reasserts exactly 16 cycles after rst deasserts.
